// File: rtl/mux2_rr_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_feeder
// Brief    : Two-channel round-robin arbiter with registered sel/data output
//            stage and per-channel acceptance counters.
// Revision : 1.0
// ============================================================================
module mux2_rr_feeder #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [DW-1:0]    in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             r_last;
    logic [DW-1:0]    r_out_data;
    logic             r_out_sel;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic w_load_en;
    logic w_acc0;
    logic w_acc1;

    // Ready depends only on the other channel's valid and the fairness pointer,
    // so at most one channel can see ready while its peer is also valid.
    assign w_load_en = ~r_out_valid | out_ready;
    assign in0_ready = w_load_en & (~in1_valid |  r_last);
    assign in1_ready = w_load_en & (~in0_valid | ~r_last);
    assign w_acc0    = in0_valid & in0_ready;
    assign w_acc1    = in1_valid & in1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_out_data  <= '0;
            r_out_sel   <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else if (w_acc0) begin
            r_out_data  <= in0_data;
            r_out_sel   <= 1'b0;
            r_out_valid <= 1'b1;
            r_last      <= 1'b0;
            r_cnt0      <= r_cnt0 + 1'b1;
        end else if (w_acc1) begin
            r_out_data  <= in1_data;
            r_out_sel   <= 1'b1;
            r_out_valid <= 1'b1;
            r_last      <= 1'b1;
            r_cnt1      <= r_cnt1 + 1'b1;
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_rr_feeder
// Brief    : Vector table, directed corner sequences and randomized traffic
//            against a queue-free fairness model of the feeder.
// Revision : 1.0
// ============================================================================
module tb_mux2_rr_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in0_data, in1_data;
    logic       in0_valid, in1_valid, out_ready;
    logic       in0_ready, in1_ready, out_sel, out_valid;
    logic [7:0] out_data;
    logic [15:0] cnt0, cnt1;

    logic       s_in0_ready, s_in1_ready, s_out_sel, s_out_valid;
    logic [7:0] s_out_data;
    logic [3:0] s_cnt0, s_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit       m_ov;
    bit [7:0] m_data;
    bit       m_sel;
    bit       m_last;
    int       m_c0, m_c1;

    mux2_rr_feeder #(.DW(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
    );

    mux2_rr_feeder #(.DW(8), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(s_in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(s_in1_ready),
        .out_data(s_out_data), .out_sel(s_out_sel), .out_valid(s_out_valid),
        .out_ready(out_ready), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v0;
        bit [7:0] d0;
        bit       v1;
        bit [7:0] d1;
        bit       ordy;
        bit       eov;
        bit [7:0] edata;
        bit       esel;
        int       ec0;
        int       ec1;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel wins given the two requests and the fairness pointer (-1: none)
    function automatic int winner(bit a, bit b, bit last);
        if (a && b) return last ? 0 : 1;
        if (a)      return 0;
        if (b)      return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_data = 0; m_sel = 0; m_last = 1; m_c0 = 0; m_c1 = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_ov);
        chk({tag, ".out_data"},  out_data,  m_data);
        chk({tag, ".out_sel"},   out_sel,   m_sel);
        chk({tag, ".cnt0"},      cnt0,      m_c0 % 65536);
        chk({tag, ".cnt1"},      cnt1,      m_c1 % 65536);
        chk({tag, ".s_cnt0"},    s_cnt0,    m_c0 % 16);
        chk({tag, ".s_cnt1"},    s_cnt1,    m_c1 % 16);
    endtask

    // Called at posedge+1; returns at next posedge+1.
    task automatic step(input bit v0, input bit [7:0] d0, input bit v1,
                        input bit [7:0] d1, input bit ordy, input string tag);
        bit ld;
        int g;
        in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = ordy;
        ld = !m_ov || ordy;
        #3;
        // A channel is ready exactly when it would win if it were requesting.
        chk({tag, ".in0_ready"}, in0_ready, ld && winner(1'b1, v1, m_last) == 0);
        chk({tag, ".in1_ready"}, in1_ready, ld && winner(v0, 1'b1, m_last) == 1);
        @(posedge clk);
        g = ld ? winner(v0, v1, m_last) : -1;
        if (g == 0) begin
            m_data = d0; m_sel = 0; m_ov = 1; m_last = 0; m_c0++;
        end else if (g == 1) begin
            m_data = d1; m_sel = 1; m_ov = 1; m_last = 1; m_c1++;
        end else if (ld) begin
            m_ov = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            tv[i].v0 = 1; tv[i].d0 = 8'hA0; tv[i].v1 = 1; tv[i].d1 = 8'hB1; tv[i].ordy = 1;
            tv[i].eov = 1; tv[i].esel = i[0]; tv[i].edata = i[0] ? 8'hB1 : 8'hA0;
            tv[i].ec0 = (i + 2) / 2; tv[i].ec1 = (i + 1) / 2;
        end
        tv[6] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 4, 3};
        tv[7] = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 5, 3};
        tv[8] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 6, 3};
        tv[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b0, 6, 3};

        rst_n = 1'b0;
        in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table: contention from reset, then channel 0 alone, then idle
        for (int i = 0; i < 10; i++) begin
            step(tv[i].v0, tv[i].d0, tv[i].v1, tv[i].d1, tv[i].ordy, $sformatf("tv%0d", i));
            chk($sformatf("tv%0d.ov", i),   out_valid, tv[i].eov);
            chk($sformatf("tv%0d.data", i), out_data,  tv[i].edata);
            chk($sformatf("tv%0d.sel", i),  out_sel,   tv[i].esel);
            chk($sformatf("tv%0d.c0", i),   cnt0,      tv[i].ec0);
            chk($sformatf("tv%0d.c1", i),   cnt1,      tv[i].ec1);
        end

        // Backpressure holds the word and blocks both channels
        do_reset();
        step(0, 8'h00, 1, 8'h5A, 1, "bp_load");
        for (int i = 0; i < 4; i++) begin
            step(1, 8'hC0, 1, 8'hC1, 0, "bp_hold");
            chk("bp.in0_ready", in0_ready, 1'b0);
            chk("bp.in1_ready", in1_ready, 1'b0);
            chk("bp.data", out_data, 8'h5A);
            chk("bp.sel",  out_sel,  1'b1);
            chk("bp.cnt1", cnt1,     16'd1);
        end
        step(1, 8'hC0, 1, 8'hC1, 1, "bp_release");
        chk("bp_release.sel",  out_sel,  1'b0);
        chk("bp_release.data", out_data, 8'hC0);

        // Drain and refill in the same cycle: no bubble
        step(0, 8'h00, 1, 8'h77, 1, "refill");
        chk("refill.ov",   out_valid, 1'b1);
        chk("refill.data", out_data,  8'h77);
        chk("refill.sel",  out_sel,   1'b1);

        // Asynchronous reset mid-cycle while holding a word
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset.ov",   out_valid, 1'b0);
        chk("areset.data", out_data,  8'h00);
        chk("areset.sel",  out_sel,   1'b0);
        chk("areset.cnt0", cnt0,      16'd0);
        chk("areset.cnt1", cnt1,      16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1, 8'hE0, 1, 8'hE1, 1, "post_reset_tie");
        chk("post_reset_tie.sel", out_sel, 1'b0);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) step(1, i[7:0], 0, 8'h00, 1, "wrap");
        chk("wrap.s_cnt0", s_cnt0, 4'd1);
        chk("wrap.cnt0",   cnt0,   16'd17);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom),
                 $urandom_range(0, 3) != 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux2_rr_feeder.md
# mux2_rr_feeder

Two-channel round-robin arbiter and output register that feeds a 2:1 data multiplexer. It accepts words from two valid/ready source channels and picks one per cycle, alternating fairly under contention. It presents the chosen word together with the select value that produced it, so the downstream mux stage receives a stable `sel`/data pair. Per-channel acceptance counters support debug and bench scoreboarding.

## Interface
Parameters:
- `DW`, 8, data width of each channel and of the output.
- `CNT_W`, 16, width of each per-channel acceptance counter.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `in0_data`, input, DW, channel 0 word.
- `in0_valid`, input, 1, channel 0 word present.
- `in0_ready`, output, 1, channel 0 word accepted this cycle when high with `in0_valid`.
- `in1_data`, input, DW, channel 1 word.
- `in1_valid`, input, 1, channel 1 word present.
- `in1_ready`, output, 1, channel 1 accept.
- `out_data`, output, DW, registered selected word.
- `out_sel`, output, 1, registered channel index of `out_data`; 0 means channel 0, 1 means channel 1.
- `out_valid`, output, 1, the output register holds a word.
- `out_ready`, input, 1, downstream consumes when high with `out_valid`.
- `cnt0`, output, CNT_W, number of words accepted from channel 0.
- `cnt1`, output, CNT_W, number of words accepted from channel 1.

## Operation
- Reset is asynchronous and active-low: `rst_n` = 0 forces all state immediately, regardless of `clk`.
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `cnt0`=0, `cnt1`=0, internal `last`=1. With `last`=1, channel 0 wins the first tie.
- `load_en` = !`out_valid` | `out_ready`. The output register is either empty or being drained this cycle.
- Grant rules, all combinational:
  - Only `in0_valid` high: grant 0.
  - Only `in1_valid` high: grant 1.
  - Both high: grant !`last`.
  - Neither high: no grant.
- `in0_ready` = `load_en` & (!`in1_valid` | `last`==1).
- `in1_ready` = `load_en` & (!`in0_valid` | `last`==0).
- `in_ready` never depends on the channel's own valid. At most one accept occurs per cycle.
- On an accept from channel g:
  - `out_data` <= `ing_data`, `out_sel` <= g, `out_valid` <= 1.
  - `last` <= g.
  - `cntg` <= `cntg` + 1, wrapping modulo 2^CNT_W.
- On `load_en` with no accept: `out_valid` <= 0. `out_data`, `out_sel` and `last` hold.
- While `out_valid` & !`out_ready`: `out_data`, `out_sel` and `out_valid` hold stable. Both `in_ready` are 0.
- Reset mid-transfer: any word held in the output register is dropped. Counters and `last` return to their reset values.

## Timing
- Latency: a word accepted in cycle N appears on `out_data`/`out_valid` in cycle N+1.
- Throughput: one word per cycle when `out_ready` is held high.
- Simultaneous drain and accept in the same cycle is legal and loses no cycle: `out_valid` stays 1 and takes the new word.
- Under continuous dual contention with `out_ready`=1, `out_sel` alternates 0,1,0,1,… starting with 0 after reset.
- A single active channel is granted every cycle; the `last` pointer does not block it.
- Counter wrap: `cnt` at 2^CNT_W−1 plus one accept yields 0, with no flag.
- No combinational path from `in0_data`/`in1_data` to any output. `in_ready` depends combinationally on `out_ready`, `out_valid`, the other channel's valid, and `last`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle with `out_valid`=1 -> all outputs 0 immediately, without waiting for a clock edge; first tie after release grants channel 0.
- **Single channel:** `in0_valid`=1 with data 0x11,0x22,0x33 on consecutive cycles, `in1_valid`=0, `out_ready`=1 -> outputs 0x11,0x22,0x33 with `out_sel`=0 one cycle later each; `cnt0`=3, `cnt1`=0.
- **Contention:** both valid every cycle, `in0_data`=0xA0, `in1_data`=0xB1, `out_ready`=1 for 6 cycles -> `out_sel` 0,1,0,1,0,1, data alternates 0xA0/0xB1; `cnt0`=`cnt1`=3.
- **Backpressure:** load 0x5A from channel 1, then `out_ready`=0 for 4 cycles with both channels valid -> `out_data`=0x5A and `out_sel`=1 held; both `in_ready`=0; no counter change. Raise `out_ready` -> channel 0 is granted next.
- **Drain and refill:** `out_valid`=1, `out_ready`=1, `in1_valid`=1 in the same cycle -> `out_valid` stays 1 and the new word appears next cycle with no bubble.
- **Counter wrap:** with CNT_W=4, accept 17 words on channel 0 -> `cnt0`=1.
